// File: rtl/recipe_dispense_sequencer_if.sv
// Handshake bundle between the payment/selection FSM (master) and the
// recipe dispense sequencer (slave) driving the ingredient valves.
interface recipe_dispense_sequencer_if;
    logic       start;
    logic [1:0] bebida;
    logic [1:0] azucar_lvl;
    logic       abort;
    logic       agua;
    logic       cafe;
    logic       leche;
    logic       choco;
    logic       azucar;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [2:0] stage;

    modport master (
        output start, bebida, azucar_lvl, abort,
        input  agua, cafe, leche, choco, azucar, busy, done, aborted, stage
    );

    modport slave (
        input  start, bebida, azucar_lvl, abort,
        output agua, cafe, leche, choco, azucar, busy, done, aborted, stage
    );
endinterface

// File: rtl/recipe_dispense_sequencer.sv
// Steps the dispenser valves through water, coffee, milk, chocolate, sugar
// with recipe-specific tick durations; zero-length stages are skipped.
//
// state     | meaning
// ST_IDLE   | waiting for start (abort has priority and blocks it)
// ST_RUN    | one valve open, stage timer running
// ST_FINISH | one-cycle done pulse, all valves closed
module recipe_dispense_sequencer #(
    parameter int TICK_DIV = 50000,
    parameter int DUR_W    = 4
) (
    input logic                        clk,
    input logic                        rst,
    recipe_dispense_sequencer_if.slave if_seq
);
    localparam int                PRE_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_RELOAD = PRE_W'(TICK_DIV - 1);
    localparam logic [1:0]        ST_IDLE    = 2'd0;
    localparam logic [1:0]        ST_RUN     = 2'd1;
    localparam logic [1:0]        ST_FINISH  = 2'd2;
    localparam logic [2:0]        STG_NONE   = 3'd7;

    logic [1:0]       r_state;
    logic [2:0]       r_stage;
    logic [1:0]       r_bebida;
    logic [1:0]       r_sugar;
    logic [PRE_W-1:0] r_pre;
    logic [DUR_W-1:0] r_ticks;
    logic             r_aborted;

    logic [2:0]       w_first;
    logic [2:0]       w_next;
    logic [DUR_W-1:0] w_first_dur;
    logic [DUR_W-1:0] w_next_dur;
    logic             w_run;

    function automatic logic [DUR_W-1:0] f_dur(input logic [2:0] s, input logic [1:0] b,
                                              input logic [1:0] z);
        logic [DUR_W-1:0] d;
        d = '0;
        case (s)
            3'd0: case (b)
                2'd0:    d = DUR_W'(3);
                2'd1:    d = DUR_W'(2);
                2'd2:    d = DUR_W'(2);
                default: d = DUR_W'(1);
            endcase
            3'd1: case (b)
                2'd2:    d = '0;
                default: d = DUR_W'(2);
            endcase
            3'd2: case (b)
                2'd0:    d = '0;
                2'd2:    d = DUR_W'(1);
                default: d = DUR_W'(2);
            endcase
            3'd3: case (b)
                2'd2:    d = DUR_W'(3);
                2'd3:    d = DUR_W'(2);
                default: d = '0;
            endcase
            3'd4:    d = DUR_W'(z);
            default: d = '0;
        endcase
        return d;
    endfunction

    // Lowest stage index >= from with a non-zero duration, STG_NONE if none left.
    function automatic logic [2:0] f_next(input logic [2:0] from, input logic [1:0] b,
                                         input logic [1:0] z);
        logic [2:0] n;
        n = STG_NONE;
        for (int i = 4; i >= 0; i--) begin
            if ((3'(i) >= from) && (f_dur(3'(i), b, z) != '0)) n = 3'(i);
        end
        return n;
    endfunction

    assign w_first     = f_next(3'd0, if_seq.bebida, if_seq.azucar_lvl);
    assign w_first_dur = f_dur(w_first, if_seq.bebida, if_seq.azucar_lvl);
    assign w_next      = f_next(r_stage + 3'd1, r_bebida, r_sugar);
    assign w_next_dur  = f_dur(w_next, r_bebida, r_sugar);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_stage   <= STG_NONE;
            r_bebida  <= '0;
            r_sugar   <= '0;
            r_pre     <= '0;
            r_ticks   <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (if_seq.start && !if_seq.abort) begin
                        r_bebida <= if_seq.bebida;
                        r_sugar  <= if_seq.azucar_lvl;
                        r_pre    <= PRE_RELOAD;
                        r_ticks  <= w_first_dur - DUR_W'(1);
                        r_stage  <= w_first;
                        r_state  <= (w_first == STG_NONE) ? ST_FINISH : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (if_seq.abort) begin
                        r_aborted <= 1'b1;
                        r_stage   <= STG_NONE;
                        r_state   <= ST_IDLE;
                    end else if (r_pre != '0) begin
                        r_pre <= r_pre - PRE_W'(1);
                    end else if (r_ticks != '0) begin
                        r_ticks <= r_ticks - DUR_W'(1);
                        r_pre   <= PRE_RELOAD;
                    end else if (w_next == STG_NONE) begin
                        r_stage <= STG_NONE;
                        r_state <= ST_FINISH;
                    end else begin
                        // Next valve opens on the very next cycle: no gap, no overlap.
                        r_stage <= w_next;
                        r_ticks <= w_next_dur - DUR_W'(1);
                        r_pre   <= PRE_RELOAD;
                    end
                end
                ST_FINISH: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end

    // Outputs decode registered state only, so async reset clears them at once.
    assign w_run          = (r_state == ST_RUN);
    assign if_seq.agua    = w_run && (r_stage == 3'd0);
    assign if_seq.cafe    = w_run && (r_stage == 3'd1);
    assign if_seq.leche   = w_run && (r_stage == 3'd2);
    assign if_seq.choco   = w_run && (r_stage == 3'd3);
    assign if_seq.azucar  = w_run && (r_stage == 3'd4);
    assign if_seq.busy    = w_run;
    assign if_seq.done    = (r_state == ST_FINISH);
    assign if_seq.aborted = r_aborted;
    assign if_seq.stage   = r_stage;
endmodule

// File: doc/recipe_dispense_sequencer.md
Name: recipe_dispense_sequencer

Overview:
Schedules the ingredient valves of the beverage dispenser once a drink has been paid for. It receives a drink code and a sugar level, then steps through the fixed stage order water, coffee, milk, chocolate, sugar. Each stage runs for a recipe-specific number of timer ticks, and zero-length stages are skipped. It sits between the payment/selection FSM, which issues start and abort, and the valve drivers, and it replaces per-stage external timer handshaking.

Parameters:
TICK_DIV, 50000, clk cycles per recipe tick (>=1; bench uses 4)
DUR_W, 4, width of stage duration and remaining-tick counters

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  request to begin a recipe; sampled only in IDLE
bebida  in  2  drink code: 0 black coffee, 1 coffee with milk, 2 chocolate, 3 mocha
azucar_lvl  in  2  sugar duration in ticks (0..3); overrides the recipe sugar entry
abort  in  1  cancel the running recipe
agua  out  1  water valve
cafe  out  1  coffee valve
leche  out  1  milk valve
choco  out  1  chocolate valve
azucar  out  1  sugar valve
busy  out  1  a recipe is in progress
done  out  1  one-cycle pulse when a recipe completes normally
aborted  out  1  one-cycle pulse when a recipe is cancelled
stage  out  3  active stage: 0 agua, 1 cafe, 2 leche, 3 choco, 4 azucar; 7 when not dispensing

Behaviour:
- Reset (async): state IDLE; all valves 0; busy, done and aborted 0; stage=7; latched drink, latched sugar level and counters cleared. Outputs go low immediately on rst assertion, not at the next clock edge.
- Recipe table, in ticks, order agua/cafe/leche/choco:
  - bebida 0: 3/2/0/0
  - bebida 1: 2/2/2/0
  - bebida 2: 2/0/1/3
  - bebida 3: 1/2/2/2
  - Sugar duration = azucar_lvl.
- bebida and azucar_lvl are latched at the edge where start is accepted. Later input changes have no effect on the running recipe.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 and abort=0 -> RUN. In the next cycle the first non-zero stage's valve is high.
  - abort has priority over start; start with abort=1 is ignored.
- RUN:
  - Exactly one valve is high; its index is shown on stage; busy=1.
  - A stage of D ticks keeps its valve high for exactly D*TICK_DIV cycles.
  - The prescaler and tick counter restart at every stage entry.
  - After a stage's last cycle, the next non-zero stage's valve rises in the immediately following cycle. There are no gap cycles and no overlap between valves.
  - Zero-duration stages are skipped combinationally and are never reflected on stage.
  - After the last non-zero stage -> FINISH.
  - start is ignored while in RUN.
- FINISH (1 cycle): done=1, busy=0, all valves 0, stage=7, start ignored; then -> IDLE.
- abort=1 in RUN: next cycle all valves 0, aborted=1 for one cycle, busy=0, no done pulse, -> IDLE.
- abort in IDLE or FINISH has no effect.
- Water is non-zero in every recipe, so at least one stage always runs.
- Counter widths: tick count fits in DUR_W; prescaler width = clog2(TICK_DIV), with a minimum of 1.

Test Plan:
1. TICK_DIV=4; start with bebida=0, azucar_lvl=1 at cycle 0 -> agua high cycles 1-12, cafe 13-20, azucar 21-24; done=1 at cycle 25; busy high cycles 1-24.
2. bebida=2, azucar_lvl=0 -> agua 8 cycles, leche 4 cycles, choco 12 cycles, back-to-back; cafe and azucar never high; stage sequence 0,2,3; done on the cycle after choco falls.
3. bebida=1, abort asserted in the 3rd cycle of cafe -> next cycle all valves 0, aborted=1 for 1 cycle, busy=0, done never asserted; a new start afterwards runs normally.
4. bebida=3 running; pulse start with bebida=0 and change azucar_lvl mid-run -> ignored; full mocha sequence 1/2/2/2 plus the originally latched sugar level completes.
5. Assert rst asynchronously mid-agua (between clock edges) -> all valves, busy and stage=7 take reset values immediately; after release, start with bebida=0 runs the full recipe from agua.
6. start and abort both high in IDLE -> no valve ever rises, busy stays 0, no done or aborted pulse.
